// File: rtl/pl_branch_predictor_bht.sv
// PC-indexed branch history table of saturating counters with optional gshare hashing.
// Lookup is combinational in IF; resolved branches update the table, global history and
// performance counters from EX using the index carried down the pipe.
module pl_branch_predictor_bht #(
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned PC_BITS   = 32,
  parameter int unsigned GHR_BITS  = 6,
  parameter int unsigned GSHARE    = 1,
  parameter int unsigned STAT_BITS = 32,
  localparam int unsigned IDX_BITS = $clog2(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [PC_BITS-1:0]   lookup_pc,
  output logic                 predicted_taken,
  output logic [IDX_BITS-1:0]  lookup_idx,
  input  logic                 update_valid,
  input  logic [IDX_BITS-1:0]  update_idx,
  input  logic                 update_taken,
  input  logic                 update_predicted,
  output logic                 mispredict,
  output logic [STAT_BITS-1:0] branch_count,
  output logic [STAT_BITS-1:0] mispredict_count
);

  // Weakly-not-taken reset value; zero for single-bit counters.
  localparam logic [CTR_BITS-1:0]  CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};

  logic [CTR_BITS-1:0] table_q [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q;

  logic                accept_c;
  logic                mispred_c;
  logic [IDX_BITS-1:0] pc_idx_c;
  logic [CTR_BITS-1:0] ctr_cur_c;
  logic [CTR_BITS-1:0] ctr_next_c;
  logic                unused_pc_c;

  assign accept_c  = update_valid & enable;
  assign mispred_c = update_predicted ^ update_taken;
  assign pc_idx_c  = lookup_pc[IDX_BITS+1:2];

  // Upper PC bits and the byte offset do not take part in indexing.
  assign unused_pc_c = ^{lookup_pc[PC_BITS-1:IDX_BITS+2], lookup_pc[1:0]};

  // Index hashing: plain PC bits, or PC bits XOR zero-extended global history.
  generate
    if (GSHARE != 0) begin : g_gshare
      assign lookup_idx = pc_idx_c ^ IDX_BITS'(ghr_q);
    end else begin : g_bimodal
      assign lookup_idx = pc_idx_c;
    end
  endgenerate

  // Read-before-write: lookup always sees the registered table state.
  assign predicted_taken = table_q[lookup_idx][CTR_BITS-1];

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    ctr_cur_c  = table_q[update_idx];
    ctr_next_c = ctr_cur_c;
    if (update_taken) begin
      if (ctr_cur_c != CTR_MAX) ctr_next_c = ctr_cur_c + CTR_BITS'(1);
    end else begin
      if (ctr_cur_c != '0) ctr_next_c = ctr_cur_c - CTR_BITS'(1);
    end
  end

  // Counter table storage, trained only by accepted updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) table_q[i] <= CTR_INIT;
    end else if (accept_c) begin
      table_q[update_idx] <= ctr_next_c;
    end
  end

  // Non-speculative global history: outcome shifts in at the LSB, oldest bit drops out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q <= '0;
    end else if (accept_c) begin
      ghr_q <= GHR_BITS'({ghr_q, update_taken});
    end
  end

  // One-cycle mispredict pulse for the last accepted update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mispredict <= 1'b0;
    end else begin
      mispredict <= accept_c & mispred_c;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (accept_c) begin
      if (branch_count != STAT_MAX) branch_count <= branch_count + STAT_BITS'(1);
      if (mispred_c && (mispredict_count != STAT_MAX)) begin
        mispredict_count <= mispredict_count + STAT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_pl_branch_predictor_bht.sv
// Bench for pl_branch_predictor_bht: three instances (bimodal, gshare, 4-bit stats) share
// stimulus and are compared against an array-based reference model.
module tb_pl_branch_predictor_bht;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [5:0]  update_idx;
  logic        update_taken;
  logic        update_predicted;

  logic        pred_o [N];
  logic [5:0]  idx_o  [N];
  logic        mis_o  [N];
  logic [31:0] bc0, bc1, mc0, mc1;
  logic [3:0]  bc2, mc2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int     m_tab [N][64];
  int     m_ghr [N];
  longint m_bc  [N];
  longint m_mc  [N];
  bit     m_mis [N];
  int     gs    [N] = '{0, 1, 0};
  longint smax  [N] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

  // Samples of the last cycle
  logic        obs_pred [N];
  logic [5:0]  obs_idx  [N];
  logic        obs_mis  [N];
  logic [31:0] obs_bc   [N];
  logic [31:0] obs_mc   [N];
  bit          exp_pred [N];
  int          exp_idx  [N];

  always #5 clk = ~clk;

  pl_branch_predictor_bht #(.GSHARE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .lookup_pc(lookup_pc),
    .predicted_taken(pred_o[0]), .lookup_idx(idx_o[0]), .update_valid(update_valid),
    .update_idx(update_idx), .update_taken(update_taken), .update_predicted(update_predicted),
    .mispredict(mis_o[0]), .branch_count(bc0), .mispredict_count(mc0));

  pl_branch_predictor_bht #(.GSHARE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .lookup_pc(lookup_pc),
    .predicted_taken(pred_o[1]), .lookup_idx(idx_o[1]), .update_valid(update_valid),
    .update_idx(update_idx), .update_taken(update_taken), .update_predicted(update_predicted),
    .mispredict(mis_o[1]), .branch_count(bc1), .mispredict_count(mc1));

  pl_branch_predictor_bht #(.GSHARE(0), .STAT_BITS(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .lookup_pc(lookup_pc),
    .predicted_taken(pred_o[2]), .lookup_idx(idx_o[2]), .update_valid(update_valid),
    .update_idx(update_idx), .update_taken(update_taken), .update_predicted(update_predicted),
    .mispredict(mis_o[2]), .branch_count(bc2), .mispredict_count(mc2));

  function automatic void model_reset();
    for (int d = 0; d < N; d++) begin
      for (int i = 0; i < 64; i++) m_tab[d][i] = 1;
      m_ghr[d] = 0;
      m_bc[d]  = 0;
      m_mc[d]  = 0;
      m_mis[d] = 1'b0;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; enable = 1'b0; update_valid = 1'b0;
    update_idx = '0; update_taken = 1'b0; update_predicted = 1'b0; lookup_pc = '0;
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  // One clock: drive, sample combinational outputs, advance model on the edge, sample registers.
  task automatic cycle(input logic v, input logic en, input logic [5:0] ui,
                       input logic t, input logic p, input logic [31:0] pc);
    @(negedge clk);
    update_valid = v; enable = en; update_idx = ui;
    update_taken = t; update_predicted = p; lookup_pc = pc;
    #1;
    for (int d = 0; d < N; d++) begin
      exp_idx[d]  = int'(pc[7:2]) ^ ((gs[d] != 0) ? m_ghr[d] : 0);
      exp_pred[d] = (m_tab[d][exp_idx[d]] >= 2);
      obs_pred[d] = pred_o[d];
      obs_idx[d]  = idx_o[d];
    end
    @(posedge clk);
    for (int d = 0; d < N; d++) begin
      if (v === 1'b1 && en === 1'b1) begin
        if (t) m_tab[d][ui] = (m_tab[d][ui] < 3) ? m_tab[d][ui] + 1 : 3;
        else   m_tab[d][ui] = (m_tab[d][ui] > 0) ? m_tab[d][ui] - 1 : 0;
        m_ghr[d] = ((m_ghr[d] * 2) + int'(t)) % 64;
        m_mis[d] = (p != t);
        if (m_bc[d] < smax[d]) m_bc[d]++;
        if (m_mis[d] && m_mc[d] < smax[d]) m_mc[d]++;
      end else begin
        m_mis[d] = 1'b0;
      end
    end
    #1;
    for (int d = 0; d < N; d++) obs_mis[d] = mis_o[d];
    obs_bc[0] = bc0; obs_bc[1] = bc1; obs_bc[2] = 32'(bc2);
    obs_mc[0] = mc0; obs_mc[1] = mc1; obs_mc[2] = 32'(mc2);
  endtask

  task automatic test_reset();
    logic [31:0] pc;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      pc = $urandom;
      cycle(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, pc);
      for (int d = 0; d < N; d++) begin
        checks++;
        if (obs_pred[d] !== 1'b0) begin
          errors++; $display("FAIL reset_pred dut%0d pc=%h: got %b want 0", d, pc, obs_pred[d]);
        end
        checks++;
        if (obs_idx[d] !== pc[7:2]) begin
          errors++; $display("FAIL reset_idx dut%0d: got %0d want %0d", d, obs_idx[d], pc[7:2]);
        end
        checks++;
        if (obs_mis[d] !== 1'b0 || obs_bc[d] !== 32'd0 || obs_mc[d] !== 32'd0) begin
          errors++; $display("FAIL reset_regs dut%0d: got mis=%b bc=%0d mc=%0d want 0/0/0",
                             d, obs_mis[d], obs_bc[d], obs_mc[d]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    bit ops  [12] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    bit want [13] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    do_reset();
    for (int k = 0; k < 13; k++) begin
      if (k < 12) cycle(1'b1, 1'b1, 6'd5, ops[k], 1'b0, 32'h14);
      else        cycle(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'h14);
      for (int d = 0; d < N; d += 2) begin
        checks++;
        if (obs_pred[d] !== want[k]) begin
          errors++; $display("FAIL sat_pred dut%0d step %0d: got %b want %b", d, k, obs_pred[d], want[k]);
        end
      end
      checks++;
      if (obs_idx[0] !== 6'd5) begin
        errors++; $display("FAIL sat_idx step %0d: got %0d want 5", k, obs_idx[0]);
      end
    end
  endtask

  task automatic test_gshare();
    do_reset();
    cycle(1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 32'h0);
    cycle(1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 32'h0);
    cycle(1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 32'h40);
    checks++;
    if (obs_idx[1] !== 6'd22) begin
      errors++; $display("FAIL gshare_idx: got %0d want 22", obs_idx[1]);
    end
    checks++;
    if (obs_idx[0] !== 6'd16) begin
      errors++; $display("FAIL bimodal_idx: got %0d want 16", obs_idx[0]);
    end
    cycle(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'h40);
    checks++;
    if (obs_idx[1] !== 6'd29) begin
      errors++; $display("FAIL gshare_idx_next: got %0d want 29", obs_idx[1]);
    end
  endtask

  task automatic test_bypass_and_stall();
    do_reset();
    cycle(1'b1, 1'b1, 6'd9, 1'b1, 1'b0, 32'h24);
    checks++;
    if (obs_pred[0] !== 1'b0) begin
      errors++; $display("FAIL rbw_same_cycle: got %b want 0", obs_pred[0]);
    end
    cycle(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'h24);
    checks++;
    if (obs_pred[0] !== 1'b1) begin
      errors++; $display("FAIL rbw_next_cycle: got %b want 1", obs_pred[0]);
    end
    cycle(1'b1, 1'b0, 6'bx, 1'bx, 1'bx, 32'h24);
    checks++;
    if (obs_mis[0] !== 1'b0 || obs_bc[0] !== 32'd1 || obs_mc[0] !== 32'd1) begin
      errors++; $display("FAIL stall_regs: got mis=%b bc=%0d mc=%0d want 0/1/1",
                         obs_mis[0], obs_bc[0], obs_mc[0]);
    end
    cycle(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'h24);
    checks++;
    if (obs_idx[1] !== 6'd8) begin
      errors++; $display("FAIL stall_ghr: got idx %0d want 8", obs_idx[1]);
    end
    cycle(1'b1, 1'b1, 6'd9, 1'b0, 1'b0, 32'h24);
    cycle(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'h24);
    checks++;
    if (obs_pred[0] !== 1'b0) begin
      errors++; $display("FAIL stall_table: got %b want 0", obs_pred[0]);
    end
  endtask

  task automatic test_stats();
    bit t;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      t = k[0];
      cycle(1'b1, 1'b1, 6'($urandom), t, ~t, $urandom);
      checks++;
      if (obs_mis[2] !== 1'b1) begin
        errors++; $display("FAIL stats_mis step %0d: got %b want 1", k, obs_mis[2]);
      end
    end
    checks++;
    if (obs_bc[2] !== 32'd15 || obs_mc[2] !== 32'd15) begin
      errors++; $display("FAIL stats_sat: got bc=%0d mc=%0d want 15/15", obs_bc[2], obs_mc[2]);
    end
    checks++;
    if (obs_bc[0] !== 32'd20 || obs_mc[0] !== 32'd20) begin
      errors++; $display("FAIL stats_wide: got bc=%0d mc=%0d want 20/20", obs_bc[0], obs_mc[0]);
    end
    cycle(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'h0);
    for (int d = 0; d < N; d++) begin
      checks++;
      if (obs_mis[d] !== 1'b0) begin
        errors++; $display("FAIL stats_idle_mis dut%0d: got %b want 0", d, obs_mis[d]);
      end
    end
    // Asynchronous reset pulse away from any clock edge
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bc2 !== 4'd0 || mc2 !== 4'd0 || bc0 !== 32'd0 || mc0 !== 32'd0) begin
      errors++; $display("FAIL async_reset: got bc2=%0d mc2=%0d bc0=%0d mc0=%0d want 0", bc2, mc2, bc0, mc0);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'h14);
    checks++;
    if (obs_pred[0] !== 1'b0 || obs_idx[1] !== 6'd5) begin
      errors++; $display("FAIL post_reset: got pred=%b idx=%0d want 0/5", obs_pred[0], obs_idx[1]);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      cycle(($urandom % 4) != 0, ($urandom % 8) != 0, 6'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), k[0] ? r : (r & 32'hFFFF_FF1F));
      for (int d = 0; d < N; d++) begin
        checks++;
        if (obs_pred[d] !== exp_pred[d] || obs_idx[d] !== 6'(exp_idx[d])) begin
          errors++; $display("FAIL rand_lookup dut%0d cyc %0d: got pred=%b idx=%0d want %b/%0d",
                             d, k, obs_pred[d], obs_idx[d], exp_pred[d], exp_idx[d]);
        end
        checks++;
        if (obs_mis[d] !== m_mis[d] || obs_bc[d] !== 32'(m_bc[d]) || obs_mc[d] !== 32'(m_mc[d])) begin
          errors++; $display("FAIL rand_regs dut%0d cyc %0d: got mis=%b bc=%0d mc=%0d want %b/%0d/%0d",
                             d, k, obs_mis[d], obs_bc[d], obs_mc[d], m_mis[d], m_bc[d], m_mc[d]);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; update_valid = 1'b0; update_idx = '0;
    update_taken = 1'b0; update_predicted = 1'b0; lookup_pc = '0;
    model_reset();
    test_reset();
    test_saturation();
    test_gshare();
    test_bypass_and_stall();
    test_stats();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
